// File: rtl/multi_tag_logic.sv
// Tag sequencer for a load -> compute (with reuse passes) -> store buffer pipeline.
// Tags are handed out round-robin and walk through each phase strictly in allocation order.
module multi_tag_logic #(
  parameter int NUM_TAGS      = 2,
  parameter int TAG_W         = 1,
  parameter int REUSE_CNT_W   = 3,
  parameter int STORE_ENABLED = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            tag_req,
  input  logic                            tag_reuse,
  input  logic                            tag_flush,
  input  logic                            tag_bias_prev_sw,
  input  logic                            tag_ddr_pe_sw,
  output logic                            tag_ready,
  output logic                            tag_done,
  output logic [TAG_W-1:0]                tag_id,
  output logic                            ldmem_tag_ready,
  input  logic                            ldmem_tag_done,
  output logic [TAG_W-1:0]                ldmem_tag,
  output logic                            compute_tag_ready,
  input  logic                            compute_tag_done,
  output logic [TAG_W-1:0]                compute_tag,
  output logic                            compute_bias_prev_sw,
  output logic                            stmem_tag_ready,
  input  logic                            stmem_tag_done,
  output logic [TAG_W-1:0]                stmem_tag,
  output logic                            stmem_ddr_pe_sw,
  output logic                            next_compute_tag,
  output logic                            reuse_overflow,
  output logic [3*NUM_TAGS-1:0]           dbg_tag_state,
  output logic [REUSE_CNT_W*NUM_TAGS-1:0] dbg_reuse_cnt
);

  // Handshake: each phase engine sees *_tag_ready as valid for its tag; a *_tag_done
  // input is consumed only on a rising clk edge where the matching ready is high.
  typedef enum logic [2:0] {
    TS_FREE    = 3'd0,
    TS_LDMEM   = 3'd1,
    TS_COMPUTE = 3'd2,
    TS_CHECK   = 3'd3,
    TS_STMEM   = 3'd4
  } tag_state_e;

  localparam logic [REUSE_CNT_W-1:0] CNT_ONE = REUSE_CNT_W'(1);
  localparam logic [REUSE_CNT_W-1:0] CNT_MAX = '1;

  tag_state_e             state_q [NUM_TAGS];
  tag_state_e             state_d [NUM_TAGS];
  logic [REUSE_CNT_W-1:0] cnt_q   [NUM_TAGS];
  logic [REUSE_CNT_W-1:0] cnt_d   [NUM_TAGS];
  logic                   flush_q [NUM_TAGS];
  logic                   flush_d [NUM_TAGS];
  logic                   bias_q  [NUM_TAGS];
  logic                   bias_d  [NUM_TAGS];
  logic                   pend_q  [NUM_TAGS];
  logic                   pend_d  [NUM_TAGS];
  logic                   ddr_q   [NUM_TAGS];
  logic                   ddr_d   [NUM_TAGS];

  logic [TAG_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [TAG_W-1:0] ld_ptr_q, ld_ptr_d;
  logic [TAG_W-1:0] cmp_ptr_q, cmp_ptr_d;
  logic [TAG_W-1:0] st_ptr_q, st_ptr_d;
  logic [TAG_W-1:0] last_ptr_q, last_ptr_d;
  logic             ovf_q, ovf_d;

  logic             req_acc, ld_fire, cmp_fire, st_fire;
  logic             reuse_ok, reuse_sat;
  logic [TAG_W-1:0] reuse_tgt;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    if (p == TAG_W'(NUM_TAGS - 1)) return '0;
    return p + TAG_W'(1);
  endfunction

  assign tag_id               = alloc_ptr_q;
  assign ldmem_tag            = ld_ptr_q;
  assign compute_tag          = cmp_ptr_q;
  assign stmem_tag            = st_ptr_q;
  assign tag_ready            = (state_q[alloc_ptr_q] == TS_FREE);
  assign ldmem_tag_ready      = (state_q[ld_ptr_q] == TS_LDMEM);
  assign compute_tag_ready    = (state_q[cmp_ptr_q] == TS_COMPUTE);
  assign stmem_tag_ready      = (state_q[st_ptr_q] == TS_STMEM);
  assign compute_bias_prev_sw = bias_q[cmp_ptr_q];
  assign stmem_ddr_pe_sw      = ddr_q[st_ptr_q];
  assign reuse_overflow       = ovf_q;
  assign next_compute_tag     = (state_q[cmp_ptr_q] == TS_CHECK) &&
                                (cnt_q[cmp_ptr_q] == '0) && flush_q[cmp_ptr_q];

  assign req_acc  = tag_req && tag_ready;
  assign ld_fire  = ldmem_tag_ready && ldmem_tag_done;
  assign cmp_fire = compute_tag_ready && compute_tag_done;
  assign st_fire  = stmem_tag_ready && stmem_tag_done;

  // A reuse issued together with an accepted request belongs to the new tag.
  assign reuse_tgt = req_acc ? alloc_ptr_q : last_ptr_q;
  assign reuse_ok  = tag_reuse && (req_acc || ((state_q[last_ptr_q] != TS_FREE) &&
                                               (state_q[last_ptr_q] != TS_STMEM)));
  assign reuse_sat = req_acc ? (CNT_ONE == CNT_MAX) : (cnt_q[last_ptr_q] == CNT_MAX);

  always_comb begin
    tag_done = 1'b1;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (state_q[i] != TS_FREE) tag_done = 1'b0;
      dbg_tag_state[3*i +: 3]                     = state_q[i];
      dbg_reuse_cnt[REUSE_CNT_W*i +: REUSE_CNT_W] = cnt_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    bias_d      = bias_q;
    pend_d      = pend_q;
    ddr_d       = ddr_q;
    alloc_ptr_d = alloc_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    cmp_ptr_d   = cmp_ptr_q;
    st_ptr_d    = st_ptr_q;
    last_ptr_d  = last_ptr_q;
    ovf_d       = ovf_q;

    if (ld_fire) begin
      state_d[ld_ptr_q] = TS_COMPUTE;
      ld_ptr_d          = ptr_inc(ld_ptr_q);
    end

    if (cmp_fire) begin
      state_d[cmp_ptr_q] = TS_CHECK;
      if (cnt_q[cmp_ptr_q] != '0) cnt_d[cmp_ptr_q] = cnt_q[cmp_ptr_q] - CNT_ONE;
    end else if (state_q[cmp_ptr_q] == TS_CHECK) begin
      if (cnt_q[cmp_ptr_q] != '0) begin
        state_d[cmp_ptr_q] = TS_COMPUTE;
        bias_d[cmp_ptr_q]  = pend_q[cmp_ptr_q];
      end else if (flush_q[cmp_ptr_q]) begin
        state_d[cmp_ptr_q] = (STORE_ENABLED != 0) ? TS_STMEM : TS_FREE;
        cmp_ptr_d          = ptr_inc(cmp_ptr_q);
      end
    end

    if (st_fire) begin
      state_d[st_ptr_q] = TS_FREE;
      st_ptr_d          = ptr_inc(st_ptr_q);
    end

    if (req_acc) begin
      state_d[alloc_ptr_q] = TS_LDMEM;
      cnt_d[alloc_ptr_q]   = CNT_ONE;
      flush_d[alloc_ptr_q] = 1'b0;
      bias_d[alloc_ptr_q]  = tag_bias_prev_sw;
      pend_d[alloc_ptr_q]  = tag_bias_prev_sw;
      ddr_d[alloc_ptr_q]   = tag_ddr_pe_sw;
      last_ptr_d           = alloc_ptr_q;
      alloc_ptr_d          = ptr_inc(alloc_ptr_q);
    end

    // A reuse and a pass completing on the same tag cancel out.
    if (reuse_ok) begin
      pend_d[reuse_tgt] = tag_bias_prev_sw;
      ddr_d[reuse_tgt]  = tag_ddr_pe_sw;
      if (reuse_sat) begin
        ovf_d = 1'b1;
      end else if (cmp_fire && (reuse_tgt == cmp_ptr_q)) begin
        cnt_d[reuse_tgt] = cnt_q[reuse_tgt];
      end else if (req_acc) begin
        cnt_d[reuse_tgt] = CNT_ONE + CNT_ONE;
      end else begin
        cnt_d[reuse_tgt] = cnt_q[reuse_tgt] + CNT_ONE;
      end
    end

    if (tag_flush && (state_q[last_ptr_q] != TS_FREE)) flush_d[last_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_q[i] <= TS_FREE;
        cnt_q[i]   <= '0;
        flush_q[i] <= 1'b0;
        bias_q[i]  <= 1'b0;
        pend_q[i]  <= 1'b0;
        ddr_q[i]   <= 1'b0;
      end
      alloc_ptr_q <= '0;
      ld_ptr_q    <= '0;
      cmp_ptr_q   <= '0;
      st_ptr_q    <= '0;
      last_ptr_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      bias_q      <= bias_d;
      pend_q      <= pend_d;
      ddr_q       <= ddr_d;
      alloc_ptr_q <= alloc_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      cmp_ptr_q   <= cmp_ptr_d;
      st_ptr_q    <= st_ptr_d;
      last_ptr_q  <= last_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multi_tag_logic.sv
// Bench for multi_tag_logic: directed phase walks plus randomized jobs, checked by a
// scoreboard of expected compute passes, retirements and stores.
module tb_multi_tag_logic;
  localparam int N       = 4;
  localparam int TW      = 2;
  localparam int CW      = 2;
  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic tag_req, tag_reuse, tag_flush, tag_bias, tag_ddr;
  logic tag_ready, tag_done, ldmem_tag_ready, compute_tag_ready, stmem_tag_ready;
  logic [TW-1:0] tag_id, ldmem_tag, compute_tag, stmem_tag;
  logic compute_bias_prev_sw, stmem_ddr_pe_sw, next_compute_tag, reuse_overflow;
  logic [3*N-1:0]  dbg_tag_state;
  logic [CW*N-1:0] dbg_reuse_cnt;
  logic ldmem_tag_done, compute_tag_done, stmem_tag_done;
  logic man_ld, man_cmp, man_st, auto_ld, auto_cmp, auto_st, auto_en;

  logic        building;
  int          build_tag;
  logic [TW:0] exp_cmp_q[$];  // {tag, bias} per compute pass
  logic [TW-1:0] exp_ret_q[$];
  logic [TW:0] exp_st_q[$];   // {tag, ddr} per store
  int checks, errors, pulse_cnt, model_alloc;
  bit exp_ovf;

  assign ldmem_tag_done   = auto_en ? auto_ld  : man_ld;
  assign compute_tag_done = auto_en ? auto_cmp : man_cmp;
  assign stmem_tag_done   = auto_en ? auto_st  : man_st;

  multi_tag_logic #(.NUM_TAGS(N), .TAG_W(TW), .REUSE_CNT_W(CW), .STORE_ENABLED(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .tag_req(tag_req), .tag_reuse(tag_reuse), .tag_flush(tag_flush),
    .tag_bias_prev_sw(tag_bias), .tag_ddr_pe_sw(tag_ddr),
    .tag_ready(tag_ready), .tag_done(tag_done), .tag_id(tag_id),
    .ldmem_tag_ready(ldmem_tag_ready), .ldmem_tag_done(ldmem_tag_done), .ldmem_tag(ldmem_tag),
    .compute_tag_ready(compute_tag_ready), .compute_tag_done(compute_tag_done),
    .compute_tag(compute_tag), .compute_bias_prev_sw(compute_bias_prev_sw),
    .stmem_tag_ready(stmem_tag_ready), .stmem_tag_done(stmem_tag_done),
    .stmem_tag(stmem_tag), .stmem_ddr_pe_sw(stmem_ddr_pe_sw),
    .next_compute_tag(next_compute_tag), .reuse_overflow(reuse_overflow),
    .dbg_tag_state(dbg_tag_state), .dbg_reuse_cnt(dbg_reuse_cnt)
  );

  always #5 clk = ~clk;

  function automatic int st_of(input int i);
    return int'(dbg_tag_state[3*i +: 3]);
  endfunction

  function automatic int cnt_of(input int i);
    return int'(dbg_reuse_cnt[CW*i +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic clear_inputs();
    tag_req = 1'b0; tag_reuse = 1'b0; tag_flush = 1'b0; tag_bias = 1'b0; tag_ddr = 1'b0;
  endtask

  task automatic expect_job(input int tg, input int passes, input bit b_first,
                            input bit b_rest, input bit ddr, input bit retire);
    logic [TW-1:0] t;
    t = tg[TW-1:0];
    exp_cmp_q.push_back({t, b_first});
    for (int p = 1; p < passes; p++) exp_cmp_q.push_back({t, b_rest});
    if (retire) begin
      exp_ret_q.push_back(t);
      exp_st_q.push_back({t, ddr});
    end
  endtask

  task automatic drain(input int limit, input string name);
    int c;
    c = 0;
    while ((exp_cmp_q.size() + exp_ret_q.size() + exp_st_q.size() != 0) && c < limit) begin
      tick();
      c++;
    end
    if (exp_cmp_q.size() + exp_ret_q.size() + exp_st_q.size() != 0) fail(name);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    model_alloc = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic monitor();
    logic [TW:0]   e;
    logic [TW-1:0] r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (compute_tag_ready && compute_tag_done) begin
          if (exp_cmp_q.size() == 0) fail("cmp_unexpected");
          else begin
            e = exp_cmp_q.pop_front();
            check("cmp_tag", int'(compute_tag), int'(e[TW:1]));
            check("cmp_bias", int'(compute_bias_prev_sw), int'(e[0]));
          end
        end
        if (next_compute_tag) begin
          pulse_cnt++;
          if (exp_ret_q.size() == 0) fail("retire_unexpected");
          else begin
            r = exp_ret_q.pop_front();
            check("retire_tag", int'(compute_tag), int'(r));
          end
        end
        if (stmem_tag_ready && stmem_tag_done) begin
          if (exp_st_q.size() == 0) fail("store_unexpected");
          else begin
            e = exp_st_q.pop_front();
            check("store_tag", int'(stmem_tag), int'(e[TW:1]));
            check("store_ddr", int'(stmem_ddr_pe_sw), int'(e[0]));
          end
        end
      end
    end
  endtask

  task automatic ld_resp();
    forever begin
      tick();
      auto_ld = ($urandom_range(0, 2) != 0);
      if (building && ldmem_tag_ready && (int'(ldmem_tag) == build_tag)) auto_ld = 1'b0;
    end
  endtask

  task automatic cmp_resp();
    forever begin
      tick();
      auto_cmp = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic st_resp();
    forever begin
      tick();
      auto_st = ($urandom_range(0, 1) != 0);
    end
  endtask

  // One randomized job: request (optionally merged with the first reuse), reuses, flush.
  task automatic run_job();
    int nre, waitc, passes, tg;
    bit merge, rb, rd, pb, last_d, b, d;
    nre   = $urandom_range(0, 3);
    merge = (nre > 0) && ($urandom_range(0, 1) == 1);
    rb    = 1'($urandom_range(0, 1));
    rd    = 1'($urandom_range(0, 1));
    waitc = 0;
    while (!tag_ready && waitc < 500) begin
      tick();
      waitc++;
    end
    if (!tag_ready) begin
      fail("req_wait_timeout");
      return;
    end
    check("rand_tag_id", int'(tag_id), model_alloc);
    tg = model_alloc;
    building = 1'b1;
    build_tag = tg;
    tag_req = 1'b1; tag_reuse = merge; tag_bias = rb; tag_ddr = rd;
    pb = rb;
    last_d = rd;
    tick();
    clear_inputs();
    for (int i = (merge ? 1 : 0); i < nre; i++) begin
      if ($urandom_range(0, 1) == 1) tick();
      b = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      tag_reuse = 1'b1; tag_bias = b; tag_ddr = d;
      pb = b;
      last_d = d;
      tick();
      clear_inputs();
    end
    tag_flush = 1'b1;
    tick();
    clear_inputs();
    building = 1'b0;
    passes = (1 + nre > CNT_MAX) ? CNT_MAX : 1 + nre;
    if (1 + nre > CNT_MAX) exp_ovf = 1'b1;
    expect_job(tg, passes, rb, pb, last_d, 1'b1);
    model_alloc = (model_alloc + 1) % N;
  endtask

  initial begin
    int p0, c;
    checks = 0; errors = 0; pulse_cnt = 0; model_alloc = 0; exp_ovf = 1'b0;
    reset_n = 1'b0; auto_en = 1'b0; building = 1'b0; build_tag = 0;
    man_ld = 1'b0; man_cmp = 1'b0; man_st = 1'b0;
    auto_ld = 1'b0; auto_cmp = 1'b0; auto_st = 1'b0;
    clear_inputs();
    fork
      monitor();
      ld_resp();
      cmp_resp();
      st_resp();
      begin
        #900000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    tick();
    tick();
    check("rst_tag_ready", int'(tag_ready), 1);
    check("rst_tag_done", int'(tag_done), 1);
    check("rst_tag_id", int'(tag_id), 0);
    check("rst_ld_ready", int'(ldmem_tag_ready), 0);
    check("rst_cmp_ready", int'(compute_tag_ready), 0);
    check("rst_st_ready", int'(stmem_tag_ready), 0);
    check("rst_next", int'(next_compute_tag), 0);
    check("rst_ovf", int'(reuse_overflow), 0);
    reset_n = 1'b1;
    tick();

    // Single tag through every phase
    p0 = pulse_cnt;
    tag_req = 1'b1; tag_bias = 1'b1; tag_ddr = 1'b1;
    tick();
    clear_inputs();
    expect_job(0, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("walk_ldmem", st_of(0), 1);
    check("walk_tag_id", int'(tag_id), 1);
    check("walk_busy", int'(tag_done), 0);
    check("walk_ld_ready", int'(ldmem_tag_ready), 1);
    man_ld = 1'b1;
    tick();
    man_ld = 1'b0;
    check("walk_compute", st_of(0), 2);
    man_cmp = 1'b1;
    tick();
    man_cmp = 1'b0;
    check("walk_check", st_of(0), 3);
    check("walk_no_pulse", int'(next_compute_tag), 0);
    tick();
    check("walk_check_hold", st_of(0), 3);
    tag_flush = 1'b1;
    tick();
    clear_inputs();
    check("walk_pulse", int'(next_compute_tag), 1);
    tick();
    check("walk_stmem", st_of(0), 4);
    check("walk_st_ready", int'(stmem_tag_ready), 1);
    man_st = 1'b1;
    tick();
    man_st = 1'b0;
    check("walk_free", st_of(0), 0);
    check("walk_done", int'(tag_done), 1);
    check("walk_pulses", pulse_cnt - p0, 1);
    check("walk_queues", exp_cmp_q.size() + exp_ret_q.size() + exp_st_q.size(), 0);

    // Fill all tags; each request also flushes the tag before it
    do_reset();
    for (int i = 0; i < N; i++) begin
      check("fill_tag_id", int'(tag_id), i);
      tag_req = 1'b1; tag_flush = (i > 0); tag_bias = 1'(i); tag_ddr = 1'(i >> 1);
      expect_job(i, 1, 1'(i), 1'(i), 1'(i >> 1), 1'b1);
      tick();
    end
    clear_inputs();
    check("fill_not_ready", int'(tag_ready), 0);
    tag_flush = 1'b1;
    tick();
    tag_flush = 1'b0;
    tag_req = 1'b1;
    tick();
    clear_inputs();
    check("fifth_req_tag_id", int'(tag_id), 0);
    for (int i = 0; i < N; i++) check("fifth_req_state", st_of(i), 1);
    auto_en = 1'b1;
    c = 0;
    while (!tag_ready && c < 300) begin
      tick();
      c++;
    end
    check("wrap_ready", int'(tag_ready), 1);
    check("wrap_tag_id", int'(tag_id), 0);
    drain(2000, "fill_drain_timeout");
    tick();
    check("fill_done", int'(tag_done), 1);
    auto_en = 1'b0;

    // Reuse passes, merged req+reuse and merged req+flush
    do_reset();
    p0 = pulse_cnt;
    tag_req = 1'b1; tag_bias = 1'b1; tag_ddr = 1'b0;
    tick();
    clear_inputs();
    tag_reuse = 1'b1; tag_bias = 1'b1; tag_ddr = 1'b1;
    tick();
    tag_reuse = 1'b1; tag_bias = 1'b0; tag_ddr = 1'b0;
    tick();
    clear_inputs();
    check("reuse_cnt", cnt_of(0), 3);
    check("reuse_no_ovf", int'(reuse_overflow), 0);
    tag_flush = 1'b1;
    tick();
    tag_req = 1'b1; tag_reuse = 1'b1; tag_flush = 1'b0; tag_bias = 1'b0; tag_ddr = 1'b1;
    tick();
    clear_inputs();
    check("merge_reuse_cnt", cnt_of(1), 2);
    tag_req = 1'b1; tag_flush = 1'b1; tag_bias = 1'b1; tag_ddr = 1'b0;
    tick();
    clear_inputs();
    check("merge_flush_cnt", cnt_of(2), 1);
    expect_job(0, 3, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_job(1, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_job(2, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    auto_en = 1'b1;
    drain(2000, "reuse_drain_timeout");
    repeat (10) tick();
    check("unflushed_in_check", st_of(2), 3);
    check("reuse_pulses", pulse_cnt - p0, 2);
    exp_ret_q.push_back(2'd2);
    exp_st_q.push_back({2'd2, 1'b0});
    tag_flush = 1'b1;
    tick();
    tag_flush = 1'b0;
    drain(500, "late_flush_timeout");
    tick();
    check("reuse_done", int'(tag_done), 1);
    auto_en = 1'b0;

    // Reuse counter saturation
    do_reset();
    p0 = pulse_cnt;
    tag_req = 1'b1; tag_bias = 1'b0; tag_ddr = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      tag_reuse = 1'b1; tag_bias = 1'(i > 0); tag_ddr = 1'b0;
      tick();
      clear_inputs();
      if (i == 1) check("sat_pre_ovf", int'(reuse_overflow), 0);
    end
    check("sat_cnt", cnt_of(0), 3);
    check("sat_ovf", int'(reuse_overflow), 1);
    tag_flush = 1'b1;
    tick();
    clear_inputs();
    expect_job(0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    auto_en = 1'b1;
    drain(1000, "sat_drain_timeout");
    check("sat_ovf_sticky", int'(reuse_overflow), 1);
    check("sat_pulses", pulse_cnt - p0, 1);
    auto_en = 1'b0;
    tick();

    // Asynchronous reset while a tag is computing
    p0 = pulse_cnt;
    tag_req = 1'b1; tag_bias = 1'b1; tag_ddr = 1'b1;
    tick();
    clear_inputs();
    man_ld = 1'b1;
    tick();
    man_ld = 1'b0;
    check("pre_rst_cmp_ready", int'(compute_tag_ready), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_cmp_ready", int'(compute_tag_ready), 0);
    check("async_tag_ready", int'(tag_ready), 1);
    check("async_tag_done", int'(tag_done), 1);
    check("async_state", st_of(1), 0);
    check("async_ovf", int'(reuse_overflow), 0);
    check("async_tag_id", int'(tag_id), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_tag_id", int'(tag_id), 0);
    check("post_rst_ready", int'(tag_ready), 1);
    check("post_rst_pulses", pulse_cnt - p0, 0);
    model_alloc = 0;
    exp_ovf = 1'b0;

    // Randomized jobs with random engine latencies
    auto_en = 1'b1;
    for (int j = 0; j < 40; j++) run_job();
    drain(4000, "rand_drain_timeout");
    tick();
    check("rand_done", int'(tag_done), 1);
    check("rand_ovf", int'(reuse_overflow), int'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_tag_logic.md
MULTI_TAG_LOGIC -- requirements
Module: multi_tag_logic

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 2, number of buffer tags; legal range 2..8.
REQ-002 SHALL have parameter TAG_W, default 1, tag index width, equal to ceil(log2(NUM_TAGS)).
REQ-003 SHALL have parameter REUSE_CNT_W, default 3, per-tag reuse counter width.
REQ-004 SHALL have parameter STORE_ENABLED, default 1; when 0, the STMEM phase is skipped.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have ports tag_req / tag_reuse / tag_flush, input, 1 each: allocate a new tag / add one compute pass to the last-allocated tag / close the last-allocated tag.
REQ-008 SHALL have ports tag_bias_prev_sw / tag_ddr_pe_sw, input, 1 each: sideband values captured with a request or reuse.
REQ-009 SHALL have ports tag_ready / tag_done, output, 1 each: the tag at alloc_ptr is FREE / all tags are FREE.
REQ-010 SHALL have ports tag_id, output, TAG_W: index that the next accepted tag_req takes.
REQ-011 SHALL have ports ldmem_tag_ready (output, 1), ldmem_tag_done (input, 1) and ldmem_tag (output, TAG_W).
REQ-012 SHALL have ports compute_tag_ready (output, 1), compute_tag_done (input, 1), compute_tag (output, TAG_W) and compute_bias_prev_sw (output, 1).
REQ-013 SHALL have ports stmem_tag_ready (output, 1), stmem_tag_done (input, 1), stmem_tag (output, TAG_W) and stmem_ddr_pe_sw (output, 1).
REQ-014 SHALL have port next_compute_tag, output, 1: one-cycle pulse when the compute tag retires.
REQ-015 SHALL have port reuse_overflow, output, 1: sticky flag set when a reuse is dropped at counter saturation.

Function
REQ-016 SHALL keep, per tag, a registered state in {FREE=0, LDMEM=1, COMPUTE=2, CHECK=3, STMEM=4}, a reuse counter, a flush flag, bias_sw, pend_bias_sw and ddr_sw.
REQ-017 SHALL keep four TAG_W pointers, alloc_ptr, ld_ptr, cmp_ptr and st_ptr, each wrapping from NUM_TAGS-1 to 0; tags move through phases strictly in allocation order.
REQ-018 SHALL accept tag_req only when tag_ready; on acceptance: tag[alloc_ptr] goes FREE->LDMEM, its counter is set to 1, its flush flag is cleared, bias_sw and ddr_sw are captured, last_ptr<=alloc_ptr, and alloc_ptr advances.
REQ-019 SHALL ignore tag_req while tag_ready=0, with no state change.
REQ-020 SHALL treat ldmem_tag_done as valid only while ldmem_tag_ready; on it: tag[ld_ptr] LDMEM->COMPUTE and ld_ptr advances.
REQ-021 SHALL, on compute_tag_done while compute_tag_ready: tag[cmp_ptr] COMPUTE->CHECK and its counter decrements, not below 0.
REQ-022 SHALL, for a tag in CHECK: counter!=0 -> COMPUTE and bias_sw<=pend_bias_sw; counter==0 with flush=1 -> STMEM (FREE if STORE_ENABLED=0), next_compute_tag=1 for that cycle, cmp_ptr advances; counter==0 with flush=0 -> stay in CHECK.
REQ-023 SHALL, on stmem_tag_done while stmem_tag_ready: tag[st_ptr] STMEM->FREE and st_ptr advances.
REQ-024 SHALL, on tag_reuse: increment the counter of tag[last_ptr], set its pend_bias_sw<=tag_bias_prev_sw and ddr_sw<=tag_ddr_pe_sw; ignored if that tag is FREE or STMEM.
REQ-025 SHALL, on tag_reuse at counter all-ones: leave the counter unchanged and set reuse_overflow.
REQ-026 SHALL, on tag_flush: set the flush flag of tag[last_ptr]; ignored if that tag is FREE.
REQ-027 SHALL resolve simultaneous tag_req+tag_reuse by applying the reuse to the newly allocated tag (counter=2).
REQ-028 SHALL resolve simultaneous tag_req+tag_flush by applying the flush to the previous last_ptr tag.
REQ-029 SHALL leave the counter unchanged on reuse and compute_tag_done hitting the same tag in the same cycle.
REQ-030 SHALL drive ldmem_tag=ld_ptr, compute_tag=cmp_ptr, stmem_tag=st_ptr and tag_id=alloc_ptr combinationally from registers.
REQ-031 SHALL drive the ready outputs as state-of-pointer-tag compares.
REQ-032 SHALL drive compute_bias_prev_sw=bias_sw[cmp_ptr] and stmem_ddr_pe_sw=ddr_sw[st_ptr].
REQ-033 SHALL allow all phases to advance in the same cycle for different tags.

Reset
REQ-034 SHALL, while reset_n=0, immediately force all tags FREE, all pointers, last_ptr, counters, flags and sideband registers to 0, and reuse_overflow=0.
REQ-035 SHALL present, during reset, tag_ready=1, tag_done=1 and all other outputs 0; a reset mid-operation discards all tags without completion pulses.

Verification
REQ-036 SHALL cover: NUM_TAGS=2, req -> ldmem_done -> compute_done -> flush -> stmem_done gives states 1,2,3,4,0; next_compute_tag pulses once; tag_done returns to 1.
REQ-037 SHALL cover: NUM_TAGS=4, four reqs back-to-back -> tag_id 0,1,2,3, then tag_ready=0; a fifth req is ignored; after tag0 is stored, tag_ready=1 and tag_id=0 (wrap).
REQ-038 SHALL cover: req, then 2 reuses with bias 1,0, then flush -> three compute passes; compute_bias_prev_sw = req value, then 0 on the last pass; exactly one next_compute_tag.
REQ-039 SHALL cover: REUSE_CNT_W=2, req plus 3 reuses -> counter 3 and reuse_overflow=1 with counter staying 3; only 3 passes before retire.
REQ-040 SHALL cover: simultaneous req+reuse gives new-tag counter 2; simultaneous req+flush flushes the previous tag only.
REQ-041 SHALL cover: reset_n asserted mid-compute (asynchronous, between edges) -> outputs reset immediately; after release, tag_id=0 and tag_ready=1.
